// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Brief    : RV32I load/store unit. Handles byte/halfword/word accesses to a
//             word-addressed data memory with combinational read data. Sub-word
//             stores use read-modify-write. Misaligned or illegal requests
//             complete with an error and never touch memory.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_MERGE  = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q,  addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] word_q,  word_d;   // load result, or old word during read-modify-write
   logic [2:0]  f3_q,    f3_d;
   logic        we_q,    we_d;
   logic        err_q,   err_d;

   logic        w_req_err;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merged;

   // Classify an incoming request as illegal (bad funct3, unsigned store, misaligned)
   always_comb begin
      w_req_err = 1'b0;
      if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
         w_req_err = 1'b1;
      if (req_we && req_funct3[2])
         w_req_err = 1'b1;
      if (req_funct3[1:0] == 2'b01 && req_addr[0])
         w_req_err = 1'b1;
      if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
         w_req_err = 1'b1;
   end

   // Extract and extend load data; build the merged word for sub-word stores
   always_comb begin
      w_byte = mem_rd[7:0];
      case (addr_q[1:0])
         2'd0:    w_byte = mem_rd[7:0];
         2'd1:    w_byte = mem_rd[15:8];
         2'd2:    w_byte = mem_rd[23:16];
         default: w_byte = mem_rd[31:24];
      endcase
      w_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
      case (f3_q)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b100:  w_load = {24'd0, w_byte};
         3'b101:  w_load = {16'd0, w_half};
         default: w_load = mem_rd;
      endcase
      w_merged = word_q;
      if (f3_q[1:0] == 2'b00) begin
         case (addr_q[1:0])
            2'd0:    w_merged[7:0]   = wdata_q[7:0];
            2'd1:    w_merged[15:8]  = wdata_q[7:0];
            2'd2:    w_merged[23:16] = wdata_q[7:0];
            default: w_merged[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         w_merged[31:16] = wdata_q[15:0];
      end else begin
         w_merged[15:0]  = wdata_q[15:0];
      end
   end

   // Next-state and output decode; writes are gated by reset so an abort never lands
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      word_d     = word_q;
      f3_d       = f3_q;
      we_d       = we_q;
      err_d      = err_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 32'd0;
      mem_we     = 1'b0;
      mem_addr   = 32'd0;
      mem_wd     = 32'd0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               f3_d    = req_funct3;
               we_d    = req_we;
               err_d   = w_req_err;
               word_d  = 32'd0;
               state_d = w_req_err ? S_RESP : S_ACCESS;
            end
         end
         S_ACCESS: begin
            mem_addr = {addr_q[31:2], 2'b00};
            if (!we_q) begin
               word_d  = w_load;
               state_d = S_RESP;
            end else if (f3_q == 3'b010) begin
               mem_we  = ~reset;
               mem_wd  = wdata_q;
               word_d  = 32'd0;
               state_d = S_RESP;
            end else begin
               word_d  = mem_rd;
               state_d = S_MERGE;
            end
         end
         S_MERGE: begin
            mem_addr = {addr_q[31:2], 2'b00};
            mem_we   = ~reset;
            mem_wd   = w_merged;
            word_d   = 32'd0;
            state_d  = S_RESP;
         end
         default: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (err_q || we_q) ? 32'd0 : word_q;
            state_d    = S_IDLE;
         end
      endcase
   end

   // State and request registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         word_q  <= 32'd0;
         f3_q    <= 3'd0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         f3_q    <= f3_d;
         we_q    <= we_d;
         err_q   <= err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Brief    : Scoreboard bench for load_store_unit. Directed requests push the
//             expected response and expected memory write into queues; monitors
//             pop and compare when the DUT responds or writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   load_store_unit dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   always #5 clk = ~clk;

   // Data memory model with a bench-side preload port
   logic [31:0] mem [0:63];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx;
   logic [31:0] pl_data;
   assign mem_rd = mem[mem_addr[7:2]];
   always @(posedge clk) begin
      if (pl_en)       mem[pl_idx] <= pl_data;
      else if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] rd;
      logic        err;
      int          due;
   } exp_t;
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;
   exp_t exp_q[$];
   wr_t  wr_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor
   always @(negedge clk) begin
      if (resp_valid === 1'b1) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", resp_rdata, e.rd);
            chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            chk("resp_cycle", cyc, e.due);
         end
      end
   end

   // Memory write monitor
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_t w;
         if (wr_q.size() == 0) begin
            chk("unexpected_mem_we", mem_addr, 32'hFFFF_FFFF);
         end else begin
            w = wr_q.pop_front();
            chk("mem_addr", mem_addr, w.addr);
            chk("mem_wd", mem_wd, w.data);
         end
      end
   end

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = a[7:2]; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input logic wr, input logic [31:0] wr_data,
                        input logic push, input logic hold, output int t);
      int n;
      exp_t e;
      wr_t  w;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (req_ready !== 1'b1 && n < 30);
      if (req_ready !== 1'b1) begin
         chk("accept_timeout", 32'd0, 32'd1);
      end
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      t = cyc;
      if (push) begin
         e.rd = exp_rd; e.err = exp_err; e.due = cyc + lat;
         exp_q.push_back(e);
      end
      if (wr) begin
         w.addr = {addr[31:2], 2'b00}; w.data = wr_data;
         wr_q.push_back(w);
      end
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || wr_q.size() != 0 || req_ready !== 1'b1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("drain_timeout", exp_q.size() + wr_q.size(), 32'd0);
   endtask

   initial begin
      int t1, t2;
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;
      preload(32'h40, 32'h8070_60F0);
      preload(32'h44, 32'h0000_0000);
      preload(32'h48, 32'h1122_3344);
      preload(32'h4C, 32'hA5A5_A5A5);
      preload(32'h50, 32'h8070_60F0);

      // Reset state
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wd", mem_wd, 32'd0);
      reset = 1'b0;

      // Loads: we, f3, addr, wdata, exp_rdata, exp_err, latency, write?, wdata, push, hold
      issue(0, 3'b000, 32'h40, 0, 32'hFFFF_FFF0, 0, 2, 0, 0, 1, 0, t1);
      issue(0, 3'b100, 32'h41, 0, 32'h0000_0060, 0, 2, 0, 0, 1, 0, t1);
      issue(0, 3'b001, 32'h42, 0, 32'hFFFF_8070, 0, 2, 0, 0, 1, 0, t1);
      issue(0, 3'b101, 32'h42, 0, 32'h0000_8070, 0, 2, 0, 0, 1, 0, t1);
      issue(0, 3'b010, 32'h40, 0, 32'h8070_60F0, 0, 2, 0, 0, 1, 0, t1);
      issue(0, 3'b000, 32'h43, 0, 32'hFFFF_FF80, 0, 2, 0, 0, 1, 0, t1);
      issue(0, 3'b100, 32'h42, 0, 32'h0000_0070, 0, 2, 0, 0, 1, 0, t1);

      // Errors: response at T+1, no memory write
      issue(0, 3'b010, 32'h41, 0, 32'h0, 1, 1, 0, 0, 1, 0, t1);
      issue(1, 3'b001, 32'h43, 32'hFFFF, 32'h0, 1, 1, 0, 0, 1, 0, t1);
      issue(0, 3'b011, 32'h40, 0, 32'h0, 1, 1, 0, 0, 1, 0, t1);
      issue(1, 3'b100, 32'h40, 32'h55, 32'h0, 1, 1, 0, 0, 1, 0, t1);
      issue(0, 3'b110, 32'h40, 0, 32'h0, 1, 1, 0, 0, 1, 0, t1);
      drain();
      chk("mem40_after_errors", mem[16], 32'h8070_60F0);

      // Sub-word stores: write at T+2, response at T+3
      issue(1, 3'b000, 32'h42, 32'h1234_55AA, 32'h0, 0, 3, 1, 32'h80AA_60F0, 1, 0, t1);
      issue(1, 3'b001, 32'h50, 32'h0000_BEEF, 32'h0, 0, 3, 1, 32'h8070_BEEF, 1, 0, t1);
      issue(1, 3'b001, 32'h4A, 32'h0000_CAFE, 32'h0, 0, 3, 1, 32'hCAFE_3344, 1, 0, t1);
      drain();
      chk("mem40_after_sb", mem[16], 32'h80AA_60F0);
      chk("mem50_after_sh", mem[20], 32'h8070_BEEF);
      chk("mem48_after_sh", mem[18], 32'hCAFE_3344);

      // Back-to-back with req_valid held high
      issue(1, 3'b010, 32'h44, 32'h0000_0001, 32'h0, 0, 2, 1, 32'h0000_0001, 1, 1, t1);
      issue(0, 3'b010, 32'h44, 0, 32'h0000_0001, 0, 2, 0, 0, 1, 0, t2);
      chk("b2b_accept_cycle", t2, t1 + 3);
      drain();

      // Reset during MERGE of an SB: no write may land
      issue(1, 3'b000, 32'h4D, 32'h0000_0000, 32'h0, 0, 3, 0, 0, 0, 0, t1);
      @(negedge clk);                 // ACCESS
      @(negedge clk);                 // MERGE
      reset = 1'b1;
      #1;
      chk("merge_reset_mem_we", {31'd0, mem_we}, 32'd0);
      @(negedge clk);
      chk("post_reset_ready", {31'd0, req_ready}, 32'd1);
      chk("post_reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("post_reset_mem_we", {31'd0, mem_we}, 32'd0);
      reset = 1'b0;
      chk("mem4c_after_abort", mem[19], 32'hA5A5_A5A5);
      issue(0, 3'b010, 32'h4C, 0, 32'hA5A5_A5A5, 0, 2, 0, 0, 1, 0, t1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
